id_inst_queue: RTL and testbench

- Parametrised instruction buffer between IF and the ID decoder. It replaces the single if_to_id register and the direct use of inst_sram_rdata in decode.
- Captures each (pc, inst) pair in the cycle it is fetched, so SRAM read data is never lost while ID is stalled.
- Handles branch-redirect flush while preserving the MIPS delay slot.
- Presents the oldest entry to the decoder through a valid/ready handshake.

---
 rtl/id_inst_queue.sv | 99 +++++++++
 tb/tb_id_inst_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: buffers (pc, inst) pairs and keeps the MIPS delay slot on flush.
// Optional same-cycle IF-to-ID bypass on an empty queue via `define ID_QUEUE_BYPASS_EN.
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              if_ready,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  input  logic              flush,
  output logic [PTR_W:0]    count,
  output logic              stallreq
);

  localparam logic [0:0] NORMAL  = 1'b0;
  localparam logic [0:0] WAIT_DS = 1'b1;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);

  logic [PC_W-1:0]   mem_pc   [DEPTH];
  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [0:0]        state;

  logic empty, full, push, pop, flush_pop, bypass_take;

  always_comb begin
    empty    = (count == '0);
    full     = (count == CNT_FULL);
    if_ready = !full;
    stallreq = full;
`ifdef ID_QUEUE_BYPASS_EN
    id_valid    = !empty || if_valid;
    bypass_take = empty && if_valid && id_ready;
    if (empty) begin
      id_pc   = if_valid ? if_pc   : '0;
      id_inst = if_valid ? if_inst : '0;
    end else begin
      id_pc   = mem_pc[rd_ptr];
      id_inst = mem_inst[rd_ptr];
    end
`else
    id_valid    = !empty;
    bypass_take = 1'b0;
    id_pc       = empty ? '0 : mem_pc[rd_ptr];
    id_inst     = empty ? '0 : mem_inst[rd_ptr];
`endif
    // A bypassed head is consumed straight from IF and never touches storage.
    push      = if_valid && if_ready && !bypass_take;
    pop       = id_valid && id_ready && !bypass_take;
    flush_pop = pop && flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= NORMAL;
    end else if (bypass_take) begin
      state <= flush ? WAIT_DS : NORMAL;
    end else if (flush_pop && count >= CNT_TWO) begin
      // Keep only the delay slot behind the branch; any same-cycle push is dropped.
      rd_ptr <= rd_ptr + PTR_W'(1);
      wr_ptr <= rd_ptr + PTR_W'(2);
      count  <= CNT_ONE;
      state  <= NORMAL;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]   <= if_pc;
        mem_inst[wr_ptr] <= if_inst;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (flush_pop && !push)
        state <= WAIT_DS;
      else if (push)
        state <= NORMAL;
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed self-checking bench for id_inst_queue (default build; bypass expectations follow ID_QUEUE_BYPASS_EN).
module tb_id_inst_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        stallreq;

  int vecs = 0;
  int errs = 0;

  id_inst_queue #(.DEPTH(4), .PTR_W(2), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_ready(id_ready), .flush(flush), .count(count), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1; if_pc = pc; if_inst = inst;
    tick();
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL reset_id_valid: got %0b want 0", id_valid); end
    vecs++; if (if_ready !== 1'b1) begin errs++; $display("FAIL reset_if_ready: got %0b want 1", if_ready); end
    vecs++; if (stallreq !== 1'b0) begin errs++; $display("FAIL reset_stallreq: got %0b want 0", stallreq); end
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
    vecs++; if (id_pc !== 32'h0 || id_inst !== 32'h0) begin errs++; $display("FAIL reset_head: got %h/%h want 0/0", id_pc, id_inst); end
  endtask

  task automatic test_single();
    if_valid = 1'b1; if_pc = 32'hBFC0_0000; if_inst = 32'h3C01_BFAF; id_ready = 1'b0;
    #1;
`ifdef ID_QUEUE_BYPASS_EN
    vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL single_same_cycle: got %0b want 1", id_valid); end
`else
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL single_same_cycle: got %0b want 0", id_valid); end
`endif
    tick();
    if_valid = 1'b0;
    #1;
    vecs++; if (id_valid !== 1'b1) begin errs++; $display("FAIL single_valid: got %0b want 1", id_valid); end
    vecs++; if (id_pc !== 32'hBFC0_0000) begin errs++; $display("FAIL single_pc: got %h want bfc00000", id_pc); end
    vecs++; if (id_inst !== 32'h3C01_BFAF) begin errs++; $display("FAIL single_inst: got %h want 3c01bfaf", id_inst); end
    vecs++; if (count !== 3'd1) begin errs++; $display("FAIL single_count: got %0d want 1", count); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL single_pop_count: got %0d want 0", count); end
    vecs++; if (id_pc !== 32'h0) begin errs++; $display("FAIL single_pop_pc: got %h want 0", id_pc); end
  endtask

  task automatic test_fill();
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(32'(4*i), 32'h1000 + 32'(i));
    #1;
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_count: got %0d want 4", count); end
    vecs++; if (if_ready !== 1'b0) begin errs++; $display("FAIL fill_if_ready: got %0b want 0", if_ready); end
    vecs++; if (stallreq !== 1'b1) begin errs++; $display("FAIL fill_stallreq: got %0b want 1", stallreq); end
    push_one(32'h99, 32'hDEAD_BEEF);
    #1;
    vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_overflow_count: got %0d want 4", count); end
    vecs++; if (id_pc !== 32'h0) begin errs++; $display("FAIL fill_overflow_head: got %h want 0", id_pc); end
    for (int i = 0; i < 4; i++) begin
      id_ready = 1'b1;
      #1;
      vecs++; if (id_pc !== 32'(4*i) || id_inst !== 32'h1000 + 32'(i)) begin errs++; $display("FAIL fill_order[%0d]: got %h/%h want %h/%h", i, id_pc, id_inst, 32'(4*i), 32'h1000 + 32'(i)); end
      tick();
    end
    id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0 || id_valid !== 1'b0) begin errs++; $display("FAIL fill_drained: got count %0d valid %0b want 0 0", count, id_valid); end
  endtask

  task automatic test_flush_ds();
    for (int i = 0; i < 4; i++) push_one(32'h10 + 32'(4*i), 32'h2000 + 32'(i));
    id_ready = 1'b1; flush = 1'b1;
    #1;
    vecs++; if (id_pc !== 32'h10) begin errs++; $display("FAIL flush_branch_head: got %h want 10", id_pc); end
    tick();
    flush = 1'b0; id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd1) begin errs++; $display("FAIL flush_count: got %0d want 1", count); end
    vecs++; if (id_pc !== 32'h14 || id_inst !== 32'h2001) begin errs++; $display("FAIL flush_ds_head: got %h/%h want 14/2001", id_pc, id_inst); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0 || id_valid !== 1'b0) begin errs++; $display("FAIL flush_empty: got count %0d valid %0b want 0 0", count, id_valid); end
  endtask

  task automatic test_wait_ds();
    push_one(32'h20, 32'h0C00_0100);
    id_ready = 1'b1; flush = 1'b1;
    #1;
    vecs++; if (id_pc !== 32'h20) begin errs++; $display("FAIL waitds_branch_head: got %h want 20", id_pc); end
    tick();
    flush = 1'b0; id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0 || id_valid !== 1'b0) begin errs++; $display("FAIL waitds_empty: got count %0d valid %0b want 0 0", count, id_valid); end
    push_one(32'h24, 32'h0000_0024);
    #1;
    vecs++; if (id_pc !== 32'h24 || count !== 3'd1) begin errs++; $display("FAIL waitds_slot: got pc %h count %0d want 24 1", id_pc, count); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    // count == 1 with a same-cycle push: the incoming entry is the delay slot.
    push_one(32'h30, 32'h1000_0002);
    if_valid = 1'b1; if_pc = 32'h34; if_inst = 32'h0000_0034; id_ready = 1'b1; flush = 1'b1;
    tick();
    if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
    #1;
    vecs++; if (count !== 3'd1 || id_pc !== 32'h34) begin errs++; $display("FAIL flush_one_push: got pc %h count %0d want 34 1", id_pc, count); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL flush_one_push_drain: got %0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    push_one(32'h100, 32'h5000);
    push_one(32'h104, 32'h5001);
    for (int i = 0; i < 10; i++) begin
      if_valid = 1'b1; if_pc = 32'h108 + 32'(4*i); if_inst = 32'h5002 + 32'(i); id_ready = 1'b1;
      #1;
      vecs++; if (id_pc !== 32'h100 + 32'(4*i) || id_inst !== 32'h5000 + 32'(i) || count !== 3'd2) begin errs++; $display("FAIL b2b[%0d]: got pc %h inst %h count %0d want %h %h 2", i, id_pc, id_inst, count, 32'h100 + 32'(4*i), 32'h5000 + 32'(i)); end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin errs++; $display("FAIL midreset: got count %0d valid %0b pc %h want 0 0 0", count, id_valid, id_pc); end
  endtask

  task automatic test_bypass();
    if_valid = 1'b1; if_pc = 32'h40; if_inst = 32'h0000_0040; id_ready = 1'b1;
    #1;
`ifdef ID_QUEUE_BYPASS_EN
    vecs++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin errs++; $display("FAIL bypass_same: got valid %0b pc %h want 1 40", id_valid, id_pc); end
    tick();
    if_valid = 1'b0; id_ready = 1'b0;
    #1;
    vecs++; if (count !== 3'd0) begin errs++; $display("FAIL bypass_count: got %0d want 0", count); end
`else
    vecs++; if (id_valid !== 1'b0) begin errs++; $display("FAIL nobypass_same: got %0b want 0", id_valid); end
    tick();
    if_valid = 1'b0; id_ready = 1'b0;
    #1;
    vecs++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || count !== 3'd1) begin errs++; $display("FAIL nobypass_next: got valid %0b pc %h count %0d want 1 40 1", id_valid, id_pc, count); end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_flush_ds();
    test_wait_ds();
    test_back_to_back();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
